// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, LSU) and the register file write port.
// The arbiter connects through the slave modport; the sources and register file side use master.
interface regfile_wb_arbiter_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32
);
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              alu_ready;
   logic              lsu_valid;
   logic [ADDR_W-1:0] lsu_addr;
   logic [DATA_W-1:0] lsu_data;
   logic              lsu_ready;
   logic [ADDR_W-1:0] write_addr;
   logic [DATA_W-1:0] write_val;
   logic              w;

   modport master (
      output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
      input  alu_ready, lsu_ready, write_addr, write_val, w
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
      output alu_ready, lsu_ready, write_addr, write_val, w
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register file write port: round-robin or LSU-priority,
// one registered write per cycle, x0 writes suppressed, saturating stall counter.
module regfile_wb_arbiter #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ARB_MODE = 0,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   regfile_wb_arbiter_if.slave   bus,
   input  logic                  wb_hold_i,
   output logic                  last_grant_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);
   logic              alu_gnt, lsu_gnt, stall;
   logic [ADDR_W-1:0] write_addr_q;
   logic [DATA_W-1:0] write_val_q;
   logic              w_q;
   logic              last_grant_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   always_comb begin
      alu_gnt = 1'b0;
      lsu_gnt = 1'b0;
      if (!wb_hold_i) begin
         if (bus.alu_valid && bus.lsu_valid) begin
            // Round-robin: the source that did not win last time takes the conflict.
            if (ARB_MODE != 0 || !last_grant_q) begin
               lsu_gnt = 1'b1;
            end else begin
               alu_gnt = 1'b1;
            end
         end else begin
            alu_gnt = bus.alu_valid;
            lsu_gnt = bus.lsu_valid;
         end
      end
   end

   assign stall = (bus.alu_valid && !alu_gnt) || (bus.lsu_valid && !lsu_gnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         write_addr_q <= '0;
         write_val_q  <= '0;
         w_q          <= 1'b0;
         last_grant_q <= 1'b1;
         stall_cnt_q  <= '0;
      end else begin
         w_q <= 1'b0;
         if (alu_gnt) begin
            write_addr_q <= bus.alu_addr;
            write_val_q  <= bus.alu_data;
            w_q          <= (bus.alu_addr != '0);
            last_grant_q <= 1'b0;
         end else if (lsu_gnt) begin
            write_addr_q <= bus.lsu_addr;
            write_val_q  <= bus.lsu_data;
            w_q          <= (bus.lsu_addr != '0);
            last_grant_q <= 1'b1;
         end
         if (stall && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
      end
   end

   assign bus.alu_ready  = alu_gnt;
   assign bus.lsu_ready  = lsu_gnt;
   assign bus.write_addr = write_addr_q;
   assign bus.write_val  = write_val_q;
   assign bus.w          = w_q;
   assign last_grant_o   = last_grant_q;
   assign stall_cnt_o    = stall_cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a round-robin and a fixed-priority instance, with
// expected register-file writes queued by the stimulus and checked by per-instance monitors.
module tb_regfile_wb_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic hold_rr = 1'b0;
   logic hold_fp = 1'b0;
   logic       lg_rr, lg_fp;
   logic [7:0] sc_rr, sc_fp;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t q_rr[$];
   wr_t q_fp[$];

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) rr_if ();
   regfile_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) fp_if ();

   regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .ARB_MODE(0), .CNT_W(8)) dut_rr (
      .clk          (clk),
      .rst          (rst),
      .bus          (rr_if),
      .wb_hold_i    (hold_rr),
      .last_grant_o (lg_rr),
      .stall_cnt_o  (sc_rr)
   );

   regfile_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .ARB_MODE(1), .CNT_W(8)) dut_fp (
      .clk          (clk),
      .rst          (rst),
      .bus          (fp_if),
      .wb_hold_i    (hold_fp),
      .last_grant_o (lg_fp),
      .stall_cnt_o  (sc_fp)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: every asserted write enable must match the oldest queued write.
   always @(posedge clk) begin
      #1;
      if (rr_if.w === 1'b1) begin
         if (q_rr.size() == 0) begin
            check("rr_unexpected_write", 64'(rr_if.write_addr), 64'hFFFF);
         end else begin
            wr_t e;
            e = q_rr.pop_front();
            check("rr_write_addr", 64'(rr_if.write_addr), 64'(e.addr));
            check("rr_write_val", 64'(rr_if.write_val), 64'(e.data));
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (fp_if.w === 1'b1) begin
         if (q_fp.size() == 0) begin
            check("fp_unexpected_write", 64'(fp_if.write_addr), 64'hFFFF);
         end else begin
            wr_t e;
            e = q_fp.pop_front();
            check("fp_write_addr", 64'(fp_if.write_addr), 64'(e.addr));
            check("fp_write_val", 64'(fp_if.write_val), 64'(e.data));
         end
      end
   end

   task automatic clear_inputs();
      rr_if.alu_valid = 1'b0; rr_if.alu_addr = '0; rr_if.alu_data = '0;
      rr_if.lsu_valid = 1'b0; rr_if.lsu_addr = '0; rr_if.lsu_data = '0;
      fp_if.alu_valid = 1'b0; fp_if.alu_addr = '0; fp_if.alu_data = '0;
      fp_if.lsu_valid = 1'b0; fp_if.lsu_addr = '0; fp_if.lsu_data = '0;
      hold_rr = 1'b0;
      hold_fp = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      clear_inputs();
      rst = 1'b1;
      #20;
      rst = 1'b0;
      #1;
      // Reset state.
      check("reset_w", 64'(rr_if.w), 64'd0);
      check("reset_stall_cnt", 64'(sc_rr), 64'd0);
      check("reset_last_grant", 64'(lg_rr), 64'd1);
      check("reset_fp_last_grant", 64'(lg_fp), 64'd1);

      // Single ALU request: same-cycle ready, write one cycle later.
      rr_if.alu_valid = 1'b1; rr_if.alu_addr = 5'd4; rr_if.alu_data = 32'h12;
      #1;
      check("single_alu_ready", 64'(rr_if.alu_ready), 64'd1);
      check("single_lsu_ready", 64'(rr_if.lsu_ready), 64'd0);
      q_rr.push_back('{addr: 5'd4, data: 32'h12});
      @(negedge clk);
      rr_if.alu_valid = 1'b0;
      check("single_w", 64'(rr_if.w), 64'd1);
      check("single_last_grant", 64'(lg_rr), 64'd0);

      // Round-robin conflict: ALU first after reset, then LSU.
      do_reset();
      @(negedge clk);
      rr_if.alu_valid = 1'b1; rr_if.alu_addr = 5'd4;  rr_if.alu_data = 32'h12;
      rr_if.lsu_valid = 1'b1; rr_if.lsu_addr = 5'd20; rr_if.lsu_data = 32'h2;
      #1;
      check("rr_c1_alu_ready", 64'(rr_if.alu_ready), 64'd1);
      check("rr_c1_lsu_ready", 64'(rr_if.lsu_ready), 64'd0);
      q_rr.push_back('{addr: 5'd4, data: 32'h12});
      @(negedge clk);
      rr_if.alu_valid = 1'b0;
      #1;
      check("rr_c2_lsu_ready", 64'(rr_if.lsu_ready), 64'd1);
      q_rr.push_back('{addr: 5'd20, data: 32'h2});
      @(negedge clk);
      rr_if.lsu_valid = 1'b0;
      check("rr_stall_cnt", 64'(sc_rr), 64'd1);
      check("rr_last_grant", 64'(lg_rr), 64'd1);

      // Fixed priority: LSU streams three writes, ALU waits three cycles.
      do_reset();
      @(negedge clk);
      fp_if.alu_valid = 1'b1; fp_if.alu_addr = 5'd1; fp_if.alu_data = 32'hA1;
      fp_if.lsu_valid = 1'b1; fp_if.lsu_addr = 5'd2; fp_if.lsu_data = 32'hB1;
      #1;
      check("fp_c1_lsu_ready", 64'(fp_if.lsu_ready), 64'd1);
      check("fp_c1_alu_ready", 64'(fp_if.alu_ready), 64'd0);
      q_fp.push_back('{addr: 5'd2, data: 32'hB1});
      @(negedge clk);
      fp_if.lsu_addr = 5'd3; fp_if.lsu_data = 32'hB2;
      #1;
      check("fp_c2_alu_ready", 64'(fp_if.alu_ready), 64'd0);
      q_fp.push_back('{addr: 5'd3, data: 32'hB2});
      @(negedge clk);
      fp_if.lsu_addr = 5'd5; fp_if.lsu_data = 32'hB3;
      #1;
      check("fp_c3_lsu_ready", 64'(fp_if.lsu_ready), 64'd1);
      q_fp.push_back('{addr: 5'd5, data: 32'hB3});
      @(negedge clk);
      fp_if.lsu_valid = 1'b0;
      #1;
      check("fp_c4_alu_ready", 64'(fp_if.alu_ready), 64'd1);
      check("fp_stall_cnt", 64'(sc_fp), 64'd3);
      q_fp.push_back('{addr: 5'd1, data: 32'hA1});
      @(negedge clk);
      fp_if.alu_valid = 1'b0;
      check("fp_stall_cnt_after", 64'(sc_fp), 64'd3);
      check("fp_last_grant", 64'(lg_fp), 64'd0);

      // x0 write is accepted but never enables the register file.
      rr_if.lsu_valid = 1'b1; rr_if.lsu_addr = 5'd0; rr_if.lsu_data = 32'hDEADBEEF;
      #1;
      check("x0_lsu_ready", 64'(rr_if.lsu_ready), 64'd1);
      @(negedge clk);
      rr_if.lsu_valid = 1'b0;
      check("x0_w", 64'(rr_if.w), 64'd0);

      // Hold for 300 cycles: no grants, counter saturates at 255.
      do_reset();
      @(negedge clk);
      hold_rr = 1'b1;
      rr_if.alu_valid = 1'b1; rr_if.alu_addr = 5'd7; rr_if.alu_data = 32'h77;
      for (int i = 0; i < 300; i++) begin
         #1;
         check("hold_alu_ready", 64'(rr_if.alu_ready), 64'd0);
         check("hold_w", 64'(rr_if.w), 64'd0);
         @(negedge clk);
      end
      check("hold_stall_sat", 64'(sc_rr), 64'd255);
      hold_rr = 1'b0;
      #1;
      check("release_alu_ready", 64'(rr_if.alu_ready), 64'd1);
      q_rr.push_back('{addr: 5'd7, data: 32'h77});
      @(negedge clk);
      rr_if.alu_valid = 1'b0;
      check("release_w", 64'(rr_if.w), 64'd1);
      check("sat_no_wrap", 64'(sc_rr), 64'd255);

      // Mid-operation reset half a cycle after a grant.
      rr_if.alu_valid = 1'b1; rr_if.alu_addr = 5'd9; rr_if.alu_data = 32'h99;
      q_rr.push_back('{addr: 5'd9, data: 32'h99});
      @(negedge clk);
      check("midrst_w_before", 64'(rr_if.w), 64'd1);
      rr_if.alu_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_w", 64'(rr_if.w), 64'd0);
      check("midrst_stall_cnt", 64'(sc_rr), 64'd0);
      check("midrst_last_grant", 64'(lg_rr), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rr_queue_drained", 64'(q_rr.size()), 64'd0);
      check("fp_queue_drained", 64'(q_fp.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between two writeback sources: ALU results and load (LSU) results. Each source uses a valid/ready handshake. The block picks one source per cycle, round-robin or fixed-priority, and drives the register file write port (write_addr, write_val, w) from an output register. Writes to x0 are accepted but never reach the register file. A saturating counter records arbitration stalls for performance debug.

Parameters:
ADDR_W, 5, register index width
DATA_W, 32, register data width
ARB_MODE, 0, 0 = round-robin; 1 = fixed priority with LSU always winning a conflict
CNT_W, 8, stall counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous, active-high
alu_valid  input  1  ALU writeback request
alu_addr  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
alu_ready  output  1  ALU request accepted this cycle
lsu_valid  input  1  LSU writeback request
lsu_addr  input  ADDR_W  LSU destination register
lsu_data  input  DATA_W  load data
lsu_ready  output  1  LSU request accepted this cycle
wb_hold  input  1  pipeline hold; blocks all grants
write_addr  output  ADDR_W  register file write address
write_val  output  DATA_W  register file write data
w  output  1  register file write enable
last_grant  output  1  0 = ALU granted last, 1 = LSU granted last
stall_cnt  output  CNT_W  saturating count of cycles where a valid requester was not granted

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-high.
- Reset takes effect immediately, without waiting for a clock edge:
  - write_addr, write_val, w and stall_cnt go to 0.
  - last_grant goes to 1, so the ALU wins the first conflict in round-robin mode.
- Ready outputs are combinational from the valid inputs, wb_hold and last_grant.
- Grant rules:
  - If wb_hold = 1, both readies are 0.
  - If exactly one source is valid, that source gets ready = 1.
  - If both are valid and ARB_MODE = 0, the source other than last_grant is granted.
  - If both are valid and ARB_MODE = 1, the LSU is granted.
  - At most one ready is high in any cycle.
- A transfer occurs when valid && ready on a rising clk edge.
- Protocol rule for requesters: once valid is high, it stays high and addr/data stay stable until ready is seen. The block does not check this.
- last_grant updates to the granted source on every transfer and holds otherwise.
- Latency is one cycle. A transfer at edge N gives, after edge N:
  - write_addr and write_val = the transferred values;
  - w = 1, unless the transferred addr is 0, in which case w = 0.
  The register file commits at edge N+1.
- In any cycle with no transfer, w = 0 after the next edge. write_addr and write_val hold their last values.
- Throughput is one write per cycle. Back-to-back grants alternate sources when both stay valid in round-robin mode.
- stall_cnt increments by 1 at each edge where (alu_valid && !alu_ready) || (lsu_valid && !lsu_ready). It saturates at all-ones and never wraps.
- Both requesters blocked in the same cycle count as +1, not +2.
- Hold cycles with a valid requester count as stalls.
- Reset asserted mid-operation:
  - a write already on the output register is cancelled (w drops at once);
  - requests in flight are lost, and requesters must re-present them after reset.
- Simultaneous writes to the same register from both sources are serialised in grant order. The later grant's value is the final register content.
- Read/write bypass is not provided here; it belongs to the register file or forwarding unit.

Test Plan:
- Reset: assert rst for 20 ns, then check w=0, stall_cnt=0, last_grant=1. Then alu_valid=1, alu_addr=4, alu_data=0x12 → alu_ready=1 the same cycle. After the next edge: w=1, write_addr=4, write_val=0x12.
- Conflict, round-robin: hold alu (addr 4, 0x12) and lsu (addr 20, 0x2) valid for two cycles → ALU granted first, LSU second. Outputs are (4, 0x12) then (20, 0x2), stall_cnt=1, last_grant=1.
- Fixed priority: with ARB_MODE=1 and both valid, LSU is granted first and the ALU waits one cycle. Three LSU requests in a row keep the ALU stalled 3 cycles → stall_cnt=3.
- x0 discard: lsu_valid=1, lsu_addr=0, lsu_data=0xDEADBEEF → lsu_ready=1, and w stays 0 on the following cycle.
- Hold and saturation: wb_hold=1 with alu_valid=1 for 300 cycles, CNT_W=8 → alu_ready=0 throughout, w=0, stall_cnt=255. Release the hold → grant on the next cycle.
- Mid-op reset: assert rst asynchronously half a cycle after a grant → w=0 and stall_cnt=0 at once, without waiting for a clock edge, and last_grant=1.
